// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: issues EX/MEM accesses to a multi-cycle data memory,
// stalls upstream while a request is outstanding and fills the MEM/WB register.
module mem_stage_ctrl #(
   parameter int TIMEOUT   = 16,
   parameter int CNT_WIDTH = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_m,
   input  logic        memRead_m,
   input  logic        memWrite_m,
   input  logic        memToReg_m,
   input  logic        halt_m,
   input  logic [15:0] aluOut_m,
   input  logic [15:0] read2Data_m,
   input  logic [2:0]  writeRegSel_m,
   output logic        mem_en,
   output logic        mem_wr,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic        mem_done,
   input  logic [15:0] mem_rdata,
   output logic        stall_m,
   output logic        valid_w,
   output logic        memToReg_w,
   output logic        halt_w,
   output logic        err_w,
   output logic [15:0] aluOut_w,
   output logic [15:0] memData_w,
   output logic [2:0]  writeRegSel_w
);

   // state   | meaning
   // S_IDLE  | no request outstanding; accesses issue from here
   // S_WAIT  | request issued, waiting for mem_done (bounded by TIMEOUT)
   // S_HALTED| HALT retired; pipeline frozen until reset
   // S_ERROR | illegal access or timeout; pipeline frozen until reset
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HALTED, S_ERROR} state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

   state_t               state, state_nxt;
   logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
   logic                 req_wr;
   logic [15:0]          req_addr, req_wdata;
   logic                 acc, illegal, issue, load_wb, capture_data;

   assign acc     = valid_m & (memRead_m | memWrite_m);
   assign illegal = valid_m & memRead_m & memWrite_m;

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      issue        = 1'b0;
      stall_m      = 1'b0;
      load_wb      = 1'b0;
      capture_data = 1'b0;
      case (state)
         S_IDLE: begin
            stall_m = acc;
            if (illegal) begin
               state_nxt = S_ERROR;
            end else if (acc) begin
               // the strobe is suppressed while reset is held
               issue     = rst;
               state_nxt = S_WAIT;
               cnt_nxt   = '0;
            end else begin
               load_wb = 1'b1;
               if (valid_m && halt_m) state_nxt = S_HALTED;
            end
         end
         S_WAIT: begin
            if (mem_done) begin
               load_wb      = 1'b1;
               capture_data = 1'b1;
               state_nxt    = S_IDLE;
            end else begin
               stall_m = 1'b1;
               if (cnt == CNT_LAST) state_nxt = S_ERROR;
               else                 cnt_nxt   = cnt + CNT_WIDTH'(1);
            end
         end
         S_HALTED, S_ERROR: stall_m = 1'b1;
         default: state_nxt = S_IDLE;
      endcase
   end

   assign mem_en = issue;

   always_comb begin
      mem_wr    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (state == S_WAIT) begin
         mem_wr    = req_wr;
         mem_addr  = req_addr;
         mem_wdata = req_wdata;
      end else if (issue) begin
         mem_wr    = memWrite_m;
         mem_addr  = aluOut_m;
         mem_wdata = read2Data_m;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         req_wr    <= 1'b0;
         req_addr  <= '0;
         req_wdata <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (issue) begin
            req_wr    <= memWrite_m;
            req_addr  <= aluOut_m;
            req_wdata <= read2Data_m;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_w       <= 1'b0;
         memToReg_w    <= 1'b0;
         halt_w        <= 1'b0;
         err_w         <= 1'b0;
         aluOut_w      <= '0;
         memData_w     <= '0;
         writeRegSel_w <= '0;
      end else begin
         err_w <= (state_nxt == S_ERROR);
         if (load_wb) begin
            valid_w       <= valid_m;
            memToReg_w    <= memToReg_m & valid_m;
            halt_w        <= halt_m & valid_m;
            aluOut_w      <= aluOut_m;
            writeRegSel_w <= writeRegSel_m;
         end else begin
            // bubble: control cleared, data fields keep their last values
            valid_w    <= 1'b0;
            memToReg_w <= 1'b0;
            halt_w     <= (state_nxt == S_HALTED);
         end
         if (capture_data) memData_w <= req_wr ? 16'h0000 : mem_rdata;
      end
   end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed scenarios plus randomized traffic checked
// every cycle against a flag/queue-level reference model.
module tb_mem_stage_ctrl;
   localparam int TIMEOUT   = 16;
   localparam int CNT_WIDTH = 5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid_m = 0, memRead_m = 0, memWrite_m = 0, memToReg_m = 0, halt_m = 0;
   logic [15:0] aluOut_m = 0, read2Data_m = 0;
   logic [2:0]  writeRegSel_m = 0;
   logic        mem_done = 0;
   logic [15:0] mem_rdata = 0;
   logic        mem_en, mem_wr, stall_m;
   logic [15:0] mem_addr, mem_wdata;
   logic        valid_w, memToReg_w, halt_w, err_w;
   logic [15:0] aluOut_w, memData_w;
   logic [2:0]  writeRegSel_w;

   mem_stage_ctrl #(.TIMEOUT(TIMEOUT), .CNT_WIDTH(CNT_WIDTH)) dut (
      .clk(clk), .rst(rst),
      .valid_m(valid_m), .memRead_m(memRead_m), .memWrite_m(memWrite_m),
      .memToReg_m(memToReg_m), .halt_m(halt_m), .aluOut_m(aluOut_m),
      .read2Data_m(read2Data_m), .writeRegSel_m(writeRegSel_m),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_done(mem_done), .mem_rdata(mem_rdata), .stall_m(stall_m),
      .valid_w(valid_w), .memToReg_w(memToReg_w), .halt_w(halt_w), .err_w(err_w),
      .aluOut_w(aluOut_w), .memData_w(memData_w), .writeRegSel_w(writeRegSel_w)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // reference model: outstanding request, waited cycles, sticky halt/error
   logic        m_busy = 0, m_halted = 0, m_errored = 0;
   int          m_waited = 0;
   logic        m_req_wr = 0;
   logic [15:0] m_req_addr = 0, m_req_wdata = 0;
   logic        e_valid = 0, e_m2r = 0, e_halt = 0, e_err = 0;
   logic [15:0] e_alu = 0, e_mdata = 0;
   logic [2:0]  e_sel = 0;

   task automatic model_load_inputs();
      e_valid = valid_m;
      e_m2r   = memToReg_m & valid_m;
      e_halt  = halt_m & valid_m;
      e_alu   = aluOut_m;
      e_sel   = writeRegSel_m;
   endtask

   task automatic model_bubble();
      e_valid = 0;
      e_m2r   = 0;
      e_halt  = 0;
   endtask

   always @(negedge clk) begin
      logic acc, ill, x_en, x_stall;
      acc = valid_m & (memRead_m | memWrite_m);
      ill = valid_m & memRead_m & memWrite_m;
      if (!rst) begin
         chk("rst_en", mem_en, 0);
         chk("rst_stall", stall_m, acc);
         chk("rst_bus", {mem_wr, mem_addr, mem_wdata}, 0);
         chk("rst_wb", {valid_w, memToReg_w, halt_w, err_w, aluOut_w, memData_w, writeRegSel_w}, 0);
         m_busy = 0; m_halted = 0; m_errored = 0; m_waited = 0;
         e_valid = 0; e_m2r = 0; e_halt = 0; e_err = 0; e_alu = 0; e_mdata = 0; e_sel = 0;
      end else begin
         x_en = 0;
         x_stall = 1;
         if (!(m_halted || m_errored)) begin
            if (m_busy) begin
               x_stall = !mem_done;
               chk("wait_bus", {mem_wr, mem_addr, mem_wdata}, {m_req_wr, m_req_addr, m_req_wdata});
            end else begin
               x_en = acc & !ill;
               x_stall = acc;
               if (x_en)
                  chk("issue_bus", {mem_wr, mem_addr, mem_wdata}, {memWrite_m, aluOut_m, read2Data_m});
            end
         end
         chk("mem_en", mem_en, x_en);
         chk("stall_m", stall_m, x_stall);
         chk("wb_ctrl", {valid_w, memToReg_w, halt_w, err_w}, {e_valid, e_m2r, e_halt, e_err});
         chk("wb_alu", aluOut_w, e_alu);
         chk("wb_mdata", memData_w, e_mdata);
         chk("wb_sel", writeRegSel_w, e_sel);
         // advance the model to what the next edge must produce
         if (m_halted) begin
            model_bubble();
            e_halt = 1;
         end else if (m_errored) begin
            model_bubble();
         end else if (m_busy) begin
            if (mem_done) begin
               model_load_inputs();
               e_mdata = m_req_wr ? 16'h0 : mem_rdata;
               m_busy = 0;
            end else begin
               model_bubble();
               m_waited++;
               if (m_waited == TIMEOUT) begin
                  m_busy = 0;
                  m_errored = 1;
                  e_err = 1;
               end
            end
         end else if (ill) begin
            model_bubble();
            m_errored = 1;
            e_err = 1;
         end else if (acc) begin
            model_bubble();
            m_busy = 1;
            m_waited = 0;
            m_req_wr = memWrite_m;
            m_req_addr = aluOut_m;
            m_req_wdata = read2Data_m;
         end else begin
            model_load_inputs();
            if (valid_m && halt_m) m_halted = 1;
         end
      end
   end

   task automatic drive(input logic v, input logic rd, input logic wr, input logic m2r,
                        input logic h, input logic [15:0] alu, input logic [15:0] wd,
                        input logic [2:0] sel);
      valid_m = v; memRead_m = rd; memWrite_m = wr; memToReg_m = m2r; halt_m = h;
      aluOut_m = alu; read2Data_m = wd; writeRegSel_m = sel;
   endtask

   task automatic bubble();
      drive(0, 0, 0, 0, 0, 16'h0, 16'h0, 3'd0);
   endtask

   // called at posedge+1; returns at posedge+1
   task automatic do_reset();
      #1 rst = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Issue one access and complete it in the n-th WAIT cycle; called and returns at posedge+1.
   task automatic do_access(input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                            input logic [15:0] rdata, input int n, input logic [2:0] sel,
                            output int stall_cycles, output int en_cycles);
      drive(1, !wr, wr, !wr, 0, addr, wd, sel);
      mem_done = 0;
      stall_cycles = 0;
      en_cycles = 0;
      for (int k = 0; k <= n; k++) begin
         if (k == n) begin
            mem_done = 1;
            mem_rdata = rdata;
         end
         #1;
         if (k == 0) begin
            chk("acc_wr", mem_wr, wr);
            chk("acc_addr", mem_addr, addr);
            if (wr) chk("acc_wdata", mem_wdata, wd);
         end
         if (stall_m) stall_cycles++;
         if (mem_en) en_cycles++;
         @(posedge clk);
         #1;
      end
      mem_done = 0;
      bubble();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int sc, ec, n, stuck;
      #1 rst = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk);
      #1;
      chk("reset_outs", {mem_en, stall_m, valid_w, err_w, halt_w, memData_w}, 0);

      // load, 3-cycle memory
      do_access(0, 16'h1234, 16'h0, 16'hBEEF, 3, 3'd5, sc, ec);
      chk("ld_stall_cycles", sc, 3);
      chk("ld_en_cycles", ec, 1);
      chk("ld_valid_w", valid_w, 1);
      chk("ld_memData_w", memData_w, 16'hBEEF);
      chk("ld_sel_w", writeRegSel_w, 5);
      chk("ld_memToReg_w", memToReg_w, 1);

      // store, 1-cycle memory
      do_access(1, 16'h0010, 16'h00FF, 16'hAAAA, 1, 3'd2, sc, ec);
      chk("st_stall_cycles", sc, 1);
      chk("st_en_cycles", ec, 1);
      chk("st_memData_w", memData_w, 16'h0000);
      chk("st_valid_w", valid_w, 1);

      // back-to-back loads
      do_access(0, 16'h2000, 16'h0, 16'h1111, 2, 3'd1, sc, ec);
      do_access(0, 16'h2002, 16'h0, 16'h2222, 1, 3'd6, sc, ec);
      chk("b2b_en_cycles", ec, 1);
      chk("b2b_memData_w", memData_w, 16'h2222);
      chk("b2b_aluOut_w", aluOut_w, 16'h2002);

      // asynchronous reset while waiting
      drive(1, 1, 0, 1, 0, 16'h4321, 16'h0, 3'd7);
      @(posedge clk); #1;
      bubble();
      @(posedge clk); #1;
      chk("pre_rst_addr", mem_addr, 16'h4321);
      rst = 1'b0;
      #1;
      chk("async_rst_outs", {mem_en, stall_m, mem_wr, mem_addr, valid_w, err_w, memData_w}, 0);
      mem_done = 1;
      mem_rdata = 16'h5A5A;
      @(posedge clk);
      #2 rst = 1'b1;
      mem_done = 0;
      @(posedge clk); #1;
      chk("post_rst_valid_w", valid_w, 0);
      chk("post_rst_memData_w", memData_w, 0);

      // timeout
      drive(1, 1, 0, 1, 0, 16'h0BAD, 16'h0, 3'd4);
      mem_done = 0;
      n = 0;
      while (err_w !== 1'b1 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk("timeout_edges", n, TIMEOUT + 1);
      chk("timeout_stall", stall_m, 1);
      bubble();
      mem_done = 1;
      mem_rdata = 16'hFFFF;
      @(posedge clk); #1;
      mem_done = 0;
      chk("late_done_err_w", err_w, 1);
      chk("late_done_valid_w", valid_w, 0);
      do_reset();

      // illegal read+write
      drive(1, 1, 1, 0, 0, 16'h0100, 16'h0, 3'd1);
      #1;
      chk("ill_en", mem_en, 0);
      chk("ill_stall", stall_m, 1);
      @(posedge clk); #1;
      bubble();
      chk("ill_err_w", err_w, 1);
      do_reset();

      // halt
      drive(1, 0, 0, 0, 1, 16'h0042, 16'h0, 3'd3);
      #1;
      chk("halt_issue_stall", stall_m, 0);
      @(posedge clk); #1;
      chk("halt_w", {halt_w, valid_w, aluOut_w}, {1'b1, 1'b1, 16'h0042});
      drive(1, 1, 0, 1, 0, 16'h0300, 16'h0, 3'd2);
      sc = 0; ec = 0;
      for (int k = 0; k < 4; k++) begin
         #1;
         if (stall_m) sc++;
         if (mem_en) ec++;
         @(posedge clk); #1;
      end
      chk("halted_stall_cycles", sc, 4);
      chk("halted_en_cycles", ec, 0);
      chk("halted_halt_w", halt_w, 1);
      do_reset();

      // randomized traffic
      stuck = 0;
      for (int i = 0; i < 3000; i++) begin
         int op;
         op = $urandom_range(0, 63);
         valid_m       = ($urandom_range(0, 3) != 0);
         memRead_m     = (op < 24) || (op == 62);
         memWrite_m    = (op >= 24 && op < 40) || (op == 62);
         halt_m        = (op == 63);
         memToReg_m    = $urandom_range(0, 1);
         aluOut_m      = 16'($urandom);
         read2Data_m   = 16'($urandom);
         writeRegSel_m = 3'($urandom_range(0, 7));
         mem_done      = ($urandom_range(0, 3) == 0);
         mem_rdata     = 16'($urandom);
         @(posedge clk); #1;
         if (m_halted || m_errored) stuck++;
         if (stuck > 3) begin
            do_reset();
            stuck = 0;
         end
      end
      bubble();
      mem_done = 0;
      @(posedge clk); #1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage controller that consumes the EX/MEM pipeline register outputs and drives a multi-cycle data memory through a request/done handshake. While an access is outstanding, it stalls the upstream pipeline. Completed results are registered into the MEM/WB boundary. It also handles halt propagation and memory timeout/illegal-access errors.

## Interface
Parameters:
- TIMEOUT, 16: maximum cycles spent in WAIT before a timeout error is raised (≥2).
- CNT_WIDTH, 5: width of the wait counter; must satisfy 2^CNT_WIDTH > TIMEOUT.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- valid_m  input  1  EX/MEM holds a real instruction (0 = bubble).
- memRead_m  input  1  load request.
- memWrite_m  input  1  store request.
- memToReg_m  input  1  writeback selects memory data.
- halt_m  input  1  HALT instruction in the memory stage.
- aluOut_m  input  16  effective address / ALU result.
- read2Data_m  input  16  store data.
- writeRegSel_m  input  3  destination register.
- mem_en  output  1  memory request strobe.
- mem_wr  output  1  1 = write, 0 = read; valid only while mem_en=1.
- mem_addr  output  16  request address.
- mem_wdata  output  16  request write data.
- mem_done  input  1  memory completes the outstanding request this cycle.
- mem_rdata  input  16  read data; valid when mem_done=1.
- stall_m  output  1  freezes IF through EX/MEM while high.
- valid_w, memToReg_w, halt_w, err_w  output  1 each  MEM/WB control.
- aluOut_w, memData_w  output  16 each  MEM/WB data.
- writeRegSel_w  output  3  MEM/WB destination register.

## Operation
- An access is `acc = valid_m & (memRead_m | memWrite_m)`.
- The FSM has four states: IDLE, WAIT, HALTED, ERROR.

IDLE:
- When acc=1:
  - Assert `mem_en=1` combinationally.
  - Drive `mem_wr=memWrite_m`, `mem_addr=aluOut_m`, `mem_wdata=read2Data_m`.
  - Assert `stall_m=1`.
  - Go to WAIT and clear the wait counter.
- When memRead_m and memWrite_m are both set with valid_m=1, the access is illegal:
  - No request is issued (`mem_en=0`).
  - Go to ERROR.
- When valid_m=1 and halt_m=1:
  - Capture into MEM/WB as a normal non-memory instruction.
  - Go to HALTED.
- mem_done=1 while in IDLE is spurious and is ignored.

WAIT:
- `mem_en=0`. mem_wr, mem_addr and mem_wdata hold the captured request.
- `stall_m=1` except in the cycle mem_done=1.
- On mem_done=1:
  - Set `stall_m=0`.
  - Capture mem_rdata (reads) or 0 (writes) into memData_w at the edge.
  - Return to IDLE.
- Otherwise increment the counter. When the counter reaches TIMEOUT-1 without mem_done, go to ERROR.

HALTED:
- `stall_m=1`, `mem_en=0`, and `halt_w` is held at 1.
- Stays in HALTED until reset.

ERROR:
- `stall_m=1`, `mem_en=0`, and `err_w` is held at 1.
- Stays in ERROR until reset. A late mem_done is ignored.

MEM/WB register:
- Loads every edge while in IDLE or WAIT with stall_m=0:
  - `valid_w=valid_m`
  - `memToReg_w=memToReg_m & valid_m`
  - `aluOut_w=aluOut_m`
  - `writeRegSel_w=writeRegSel_m`
  - `halt_w=halt_m & valid_m`
- While stall_m=1 in IDLE/WAIT, it loads a bubble (`valid_w=0`); data fields hold their previous values.
- memData_w loads only on mem_done in WAIT; otherwise it holds.
- A new request cannot be issued in the same cycle as mem_done. The next access is issued from IDLE one cycle later.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, counter=0.
  - All outputs are 0, except mem_en and stall_m, which follow IDLE combinational rules from zeroed or driven inputs.
  - mem_en is forced to 0 while rst=0.
- Access latency is 1 + N cycles, where N is the number of cycles from the issue edge to mem_done (N ≥ 1). A non-memory instruction passes through in 1 cycle.
- stall_m is high for exactly N cycles per access: the issue cycle plus the WAIT cycles before done.
- Timeout: if mem_done never arrives, the FSM enters ERROR at the edge ending the TIMEOUT-th WAIT cycle. err_w is high the following cycle.
- Reset asserted mid-WAIT abandons the request; no MEM/WB update occurs.
- mem_done arriving in the same cycle the counter reaches TIMEOUT-1: done wins, and the FSM returns to IDLE.

## Test plan
- Reset mid-operation: put the block in WAIT, pull rst low asynchronously between edges -> all outputs 0 immediately, state IDLE, no MEM/WB capture after release.
- Load, 3-cycle memory: aluOut_m=0x1234, memRead_m=1, mem_done asserted 3 cycles after issue with mem_rdata=0xBEEF -> mem_en pulses 1 cycle with mem_addr=0x1234, stall_m high 3 cycles, then valid_w=1, memData_w=0xBEEF, writeRegSel_w captured.
- Store, 1-cycle memory: memWrite_m=1, read2Data_m=0x00FF, mem_done the next cycle -> mem_wr=1, mem_wdata=0x00FF, stall_m high 1 cycle, memData_w=0.
- Back-to-back loads: the second load is issued exactly 1 cycle after the first done, never in the done cycle; bubbles (valid_w=0) appear during stalls.
- Timeout with TIMEOUT=16, mem_done held 0 -> ERROR after 16 WAIT cycles, err_w=1, stall_m=1 persists, a late mem_done is ignored.
- Illegal read+write, then halt (after reset): the illegal access -> no mem_en, err_w=1. After reset, halt_m with valid_m=1 -> halt_w=1 next cycle, stall_m=1 forever, later accesses issue no mem_en.
